mux_bus_arbiter: RTL and testbench

//   Round-robin arbiter for the shared 8-to-1 source bus. Up to eight requesters
//   (register-file ports, ALU, immediate, I/O) compete for the bus. This block

---
 rtl/mux_bus_arbiter.sv | 109 ++++++++++
 tb/tb_mux_bus_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_bus_arbiter.sv
// Round-robin owner arbiter for the shared 8-to-1 source bus.
// Grants one requester at a time and forces rotation after a hold limit.
module mux_bus_arbiter #(
   parameter int MAX_HOLD = 15,
   parameter int HOLD_W   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arb_en,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       busy,
   output logic       preempt
);

   typedef enum logic {IDLE, OWN} state_t;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t            state, state_n;
   logic [7:0]        gnt_n;
   logic [2:0]        sel_n;
   logic [2:0]        rr_ptr, rr_n;
   logic [HOLD_W-1:0] hold_cnt, hold_n;
   logic              pre_n;
   logic [2:0]        win;
   logic [2:0]        idx;
   logic              found;
   logic              others;

   assign busy = |gnt;
   assign others = |(req & ~gnt);

   // First set request at or above rr_ptr, wrapping modulo 8.
   always_comb begin
      win   = 3'd0;
      idx   = 3'd0;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         idx = rr_ptr + 3'(k);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // Next-state, grant, hold counter and rotation pointer.
   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      sel_n   = sel;
      rr_n    = rr_ptr;
      hold_n  = hold_cnt;
      pre_n   = 1'b0;
      unique case (state)
         IDLE: begin
            gnt_n = 8'h00;
            if (arb_en && found) begin
               gnt_n   = 8'h01 << win;
               sel_n   = win;
               hold_n  = '0;
               state_n = OWN;
            end
         end
         OWN: begin
            if (!req[sel]) begin
               gnt_n   = 8'h00;
               rr_n    = sel + 3'd1;
               state_n = IDLE;
            end else if (hold_cnt == HOLD_LAST) begin
               if (others) begin
                  gnt_n   = 8'h00;
                  pre_n   = 1'b1;
                  rr_n    = sel + 3'd1;
                  state_n = IDLE;
               end
            end else begin
               hold_n = hold_cnt + 1'b1;
            end
         end
         default: begin
            gnt_n   = 8'h00;
            state_n = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops the grant immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= 8'h00;
         sel      <= 3'd0;
         rr_ptr   <= 3'd0;
         hold_cnt <= '0;
         preempt  <= 1'b0;
      end else begin
         state    <= state_n;
         gnt      <= gnt_n;
         sel      <= sel_n;
         rr_ptr   <= rr_n;
         hold_cnt <= hold_n;
         preempt  <= pre_n;
      end
   end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Self-checking bench for mux_bus_arbiter: vector table, directed
// corner sequences and randomized traffic against a cycle-count model.
module tb_mux_bus_arbiter;

   localparam int MAX_HOLD = 15;

   logic       clk;
   logic       rst;
   logic       arb_en;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       busy;
   logic       preempt;

   int checks   = 0;
   int failures = 0;

   mux_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .arb_en  (arb_en),
      .req     (req),
      .gnt     (gnt),
      .sel     (sel),
      .busy    (busy),
      .preempt (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: owner index (-1 = none), cycles owned so far,
   // next search start and last granted index.
   int m_own;
   int m_held;
   int m_ptr;
   int m_sel;
   bit m_pre;

   task automatic model_reset();
      m_own  = -1;
      m_held = 0;
      m_ptr  = 0;
      m_sel  = 0;
      m_pre  = 0;
   endtask

   task automatic model_step();
      int pick;
      m_pre = 0;
      if (m_own < 0) begin
         if (arb_en && req != 8'h00) begin
            pick = -1;
            for (int k = 0; k < 8; k++) begin
               if (pick < 0 && req[(m_ptr + k) % 8])
                  pick = (m_ptr + k) % 8;
            end
            m_own  = pick;
            m_sel  = pick;
            m_held = 1;
         end
      end else if (!req[m_own]) begin
         m_ptr = (m_own + 1) % 8;
         m_own = -1;
      end else if (m_held >= MAX_HOLD &&
                   (req & ~(8'h01 << m_own)) != 8'h00) begin
         m_pre = 1;
         m_ptr = (m_own + 1) % 8;
         m_own = -1;
      end else begin
         m_held++;
      end
   endtask

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      logic [7:0] eg;
      eg = (m_own < 0) ? 8'h00 : (8'h01 << m_own);
      chk("model_gnt", gnt, eg);
      chk("model_sel", {5'd0, sel}, 8'(m_sel));
      chk("model_busy", {7'd0, busy}, {7'd0, (eg != 8'h00)});
      chk("model_preempt", {7'd0, preempt}, {7'd0, m_pre});
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   typedef struct {
      logic [7:0] req;
      logic       en;
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       pre;
   } vec_t;

   vec_t tbl[15];

   initial begin
      tbl[0]  = '{8'h81, 1'b1, 8'h01, 3'd0, 1'b0};
      tbl[1]  = '{8'h81, 1'b1, 8'h01, 3'd0, 1'b0};
      tbl[2]  = '{8'h80, 1'b1, 8'h00, 3'd0, 1'b0};
      tbl[3]  = '{8'h80, 1'b1, 8'h80, 3'd7, 1'b0};
      tbl[4]  = '{8'h41, 1'b1, 8'h00, 3'd7, 1'b0};
      tbl[5]  = '{8'h41, 1'b1, 8'h01, 3'd0, 1'b0};
      tbl[6]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
      tbl[7]  = '{8'hFF, 1'b0, 8'h00, 3'd0, 1'b0};
      tbl[8]  = '{8'hFF, 1'b0, 8'h00, 3'd0, 1'b0};
      tbl[9]  = '{8'h04, 1'b1, 8'h04, 3'd2, 1'b0};
      tbl[10] = '{8'h00, 1'b0, 8'h00, 3'd2, 1'b0};
      tbl[11] = '{8'h04, 1'b0, 8'h00, 3'd2, 1'b0};
      tbl[12] = '{8'h04, 1'b0, 8'h00, 3'd2, 1'b0};
      tbl[13] = '{8'h04, 1'b1, 8'h04, 3'd2, 1'b0};
      tbl[14] = '{8'h00, 1'b1, 8'h00, 3'd2, 1'b0};

      rst    = 1'b1;
      req    = 8'h00;
      arb_en = 1'b0;
      model_reset();
      #12;
      chk("reset_gnt", gnt, 8'h00);
      chk("reset_sel", {5'd0, sel}, 8'h00);
      chk("reset_busy", {7'd0, busy}, 8'h00);
      chk("reset_preempt", {7'd0, preempt}, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Vector table: simultaneous requests, wrap, arb_en gating.
      for (int i = 0; i < 15; i++) begin
         req    = tbl[i].req;
         arb_en = tbl[i].en;
         tick();
         chk($sformatf("vec%0d_gnt", i), gnt, tbl[i].gnt);
         chk($sformatf("vec%0d_sel", i), {5'd0, sel}, {5'd0, tbl[i].sel});
         chk($sformatf("vec%0d_pre", i), {7'd0, preempt}, {7'd0, tbl[i].pre});
      end

      // Asynchronous reset in the middle of a grant.
      req    = 8'h04;
      arb_en = 1'b1;
      tick();
      chk("pre_rst_gnt", gnt, 8'h04);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_gnt", gnt, 8'h00);
      chk("async_rst_sel", {5'd0, sel}, 8'h00);
      chk("async_rst_busy", {7'd0, busy}, 8'h00);
      chk("async_rst_pre", {7'd0, preempt}, 8'h00);
      req = 8'h00;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

      // Preemption after exactly MAX_HOLD owned cycles.
      req    = 8'h06;
      arb_en = 1'b1;
      for (int i = 0; i < MAX_HOLD; i++) begin
         tick();
         chk($sformatf("hold%0d_gnt", i), gnt, 8'h02);
         chk($sformatf("hold%0d_pre", i), {7'd0, preempt}, 8'h00);
      end
      tick();
      chk("preempt_gnt", gnt, 8'h00);
      chk("preempt_pulse", {7'd0, preempt}, 8'h01);
      tick();
      chk("after_pre_gnt", gnt, 8'h04);
      chk("after_pre_pulse", {7'd0, preempt}, 8'h00);

      // Uncontended owner keeps the bus past the hold limit.
      req = 8'h00;
      tick();
      req = 8'h08;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk($sformatf("solo%0d_gnt", i), gnt, 8'h08);
         chk($sformatf("solo%0d_pre", i), {7'd0, preempt}, 8'h00);
      end
      req = 8'h09;
      tick();
      chk("late_pre_gnt", gnt, 8'h00);
      chk("late_pre_pulse", {7'd0, preempt}, 8'h01);
      req = 8'h00;
      tick();
      tick();

      // Randomized traffic; requests mostly held so hold limits are reached.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0)
            req = 8'($urandom);
         else if ($urandom_range(0, 15) == 0)
            req = req ^ (8'h01 << $urandom_range(0, 7));
         arb_en = ($urandom_range(0, 7) != 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
